// File: rtl/immediate_encoder_pkg.sv
// Shared ISA definitions for the immediate encoder and the decode-side extender.
// The SPLIT_* states exist only when WIDE_LI_SPLIT_EN is defined.
package immediate_encoder_pkg;

    // im_sel encodings: bit3 selects sign extension, [2:0] selects the field
    localparam logic [3:0] IM_U8    = 4'b0000;
    localparam logic [3:0] IM_U4    = 4'b0001;
    localparam logic [3:0] IM_U5    = 4'b0010;
    localparam logic [3:0] IM_U11   = 4'b0011;
    localparam logic [3:0] IM_U3    = 4'b0100;
    localparam logic [3:0] IM_SHAMT = 4'b0101;
    localparam logic [3:0] IM_S8    = 4'b1000;
    localparam logic [3:0] IM_S4    = 4'b1001;
    localparam logic [3:0] IM_S5    = 4'b1010;
    localparam logic [3:0] IM_S11   = 4'b1011;
    localparam logic [3:0] IM_S3    = 4'b1100;

    localparam logic [4:0] OP_LI    = 5'b01101;
    localparam logic [4:0] OP_SLL   = 5'b00110;
    localparam logic [4:0] OP_ADDIU = 5'b01001;

`ifdef WIDE_LI_SPLIT_EN
    typedef enum logic [1:0] {IDLE, SPLIT_SLL, SPLIT_ADD} state_t;
`else
    typedef enum logic [0:0] {IDLE} state_t;
`endif

    // Signed fit: every bit from the field's sign bit upward must match.
    function automatic logic fits_width(input logic [15:0] v, input logic [3:0] n,
                                        input logic sgn);
        logic [15:0] hi;
        if (sgn) begin
            hi = v >> (n - 4'd1);
            return (hi == 16'd0) || (hi == (16'hFFFF >> (n - 4'd1)));
        end
        hi = v >> n;
        return hi == 16'd0;
    endfunction

endpackage

// File: rtl/immediate_encoder_if.sv
// Request/response bus of the immediate encoder; slave is the encoder side.
interface immediate_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  im_sel;
    logic [15:0] template;
    logic [15:0] value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        out_fault;

    modport master (
        output in_valid, im_sel, template, value, out_ready,
        input  in_ready, out_valid, out_instr, out_fault
    );

    modport slave (
        input  in_valid, im_sel, template, value, out_ready,
        output in_ready, out_valid, out_instr, out_fault
    );
endinterface

// File: rtl/immediate_encoder_imm_field_packer.sv
// Combinational field packer: inserts the immediate into the selected field
// and reports representability; on a miss the template passes through untouched.
module imm_field_packer
    import immediate_encoder_pkg::*;
(
    input  logic [3:0]  im_sel,
    input  logic [15:0] template,
    input  logic [15:0] value,
    output logic [15:0] instr,
    output logic        fits
);

    always_comb begin
        fits  = 1'b0;
        instr = template;
        case (im_sel[2:0])
            3'b000: begin
                fits  = fits_width(value, 4'd8, im_sel[3]);
                instr = {template[15:8], value[7:0]};
            end
            3'b001: begin
                fits  = fits_width(value, 4'd4, im_sel[3]);
                instr = {template[15:4], value[3:0]};
            end
            3'b010: begin
                fits  = fits_width(value, 4'd5, im_sel[3]);
                instr = {template[15:5], value[4:0]};
            end
            3'b011: begin
                fits  = fits_width(value, 4'd11, im_sel[3]);
                instr = {template[15:11], value[10:0]};
            end
            3'b100: begin
                fits  = fits_width(value, 4'd3, im_sel[3]);
                instr = {template[15:5], value[2:0], template[1:0]};
            end
            3'b101: begin
                // shift amount 8 wraps to 000 in the 3-bit field
                fits  = !im_sel[3] && (value >= 16'd1) && (value <= 16'd8);
                instr = {template[15:5], value[2:0], template[1:0]};
            end
            default: fits = 1'b0;
        endcase
        if (!fits) instr = template;
    end

endmodule

// File: rtl/immediate_encoder.sv
// Immediate encoder: one request in, one registered instruction out (latency 1).
// Define WIDE_LI_SPLIT_EN to expand wide LI into LI/SLL/ADDIU instead of faulting.
//
// state     | meaning
// IDLE      | accepting requests; output register holds a single beat or last split beat
// SPLIT_SLL | LI beat presented, SLL beat next
// SPLIT_ADD | SLL beat presented, ADDIU beat next
module immediate_encoder
    import immediate_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    immediate_encoder_if.slave bus
);

    state_t      state;
    logic        out_valid_q;
    logic        out_fault_q;
    logic [15:0] out_instr_q;
    logic [15:0] packed_instr;
    logic        fits;
    logic        accept;

    imm_field_packer u_packer (
        .im_sel   (bus.im_sel),
        .template (bus.template),
        .value    (bus.value),
        .instr    (packed_instr),
        .fits     (fits)
    );

    assign bus.in_ready  = !rst && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_fault = out_fault_q;
    assign bus.out_instr = out_instr_q;

`ifdef WIDE_LI_SPLIT_EN
    logic       split;
    logic [7:0] hi_adj;
    logic [2:0] rx_q;
    logic [7:0] lo_q;

    // ADDIU sign-extends its byte, so pre-compensate the high byte
    assign split  = (bus.im_sel == IM_S8) && !fits;
    assign hi_adj = bus.value[15:8] + {7'd0, bus.value[7]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
            out_instr_q <= 16'h0000;
`ifdef WIDE_LI_SPLIT_EN
            rx_q        <= 3'd0;
            lo_q        <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
`ifdef WIDE_LI_SPLIT_EN
                        if (split) begin
                            out_instr_q <= {OP_LI, bus.template[10:8], hi_adj};
                            out_fault_q <= 1'b0;
                            rx_q        <= bus.template[10:8];
                            lo_q        <= bus.value[7:0];
                            state       <= SPLIT_SLL;
                        end else
`endif
                        begin
                            out_instr_q <= packed_instr;
                            out_fault_q <= !fits;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef WIDE_LI_SPLIT_EN
                SPLIT_SLL: begin
                    if (bus.out_ready) begin
                        // shift field 000 encodes a shift by 8
                        out_instr_q <= {OP_SLL, rx_q, rx_q, 5'b00000};
                        state       <= SPLIT_ADD;
                    end
                end
                SPLIT_ADD: begin
                    if (bus.out_ready) begin
                        out_instr_q <= {OP_ADDIU, rx_q, lo_q};
                        state       <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
